resonant_tank_emulator: RTL and testbench
=========================================

# resonant_tank_emulator

Hardware-in-the-loop plant model for the resonant converter. It accepts the 4-bit MOSFET command word produced by the hybrid controller and decodes it into the bridge state sigma, with shoot-through detection. It integrates a discrete-time series LC tank and returns 14-bit signed vC/iC samples, closing the control loop on-chip without the power stage.

## Interface
Parameters:
- DIV, 32'd50: clock cycles per integration step; legal range ≥ 4.
- K_I, 32'd86: current-update gain (signed, applied before right shift SH).
- K_V, 32'd90: voltage-update gain (signed, applied before right shift SH).
- R_DAMP, 32'd2: damping coefficient; used only with damping compiled in.
- SH, 32'd10: arithmetic right shift applied after each gain multiply.

Ports:
- i_clock  in  1  system clock.
- i_RESET  in  1  asynchronous, active-low reset.
- i_enable  in  1  1 = integration steps run; 0 = divider and states hold.
- i_MOSFET  in  4  gate commands [M0,M1,M2,M3]; leg A = {M0 high, M2 low}, leg B = {M1 high, M3 low}.
- i_Vg  in  16  signed DC-link voltage, same scale as o_vC<<2.
- o_vC  out  14  signed capacitor voltage = V[31:18].
- o_iC  out  14  signed inductor current = I[31:18].
- o_sigma  out  2  applied bridge state: 01 = +1, 00 = 0, 11 = −1.
- o_valid  out  1  one-cycle strobe when o_vC/o_iC/o_sigma update.
- o_fault  out  1  sticky shoot-through flag.

## Operation
- Divider: cnt counts 0..DIV−1 while i_enable=1; tick when cnt==DIV−1. cnt holds while i_enable=0.
- i_MOSFET is registered every clock (m_q). The decode uses m_q sampled on the tick cycle.
- Decode of m_q (bit order M3..M0):
  - 1001 → +1.
  - 0110 → −1.
  - 0011 or 1100 → 0 (freewheel).
  - 0000 → −sign(I), i.e. diode conduction; 0 if I==0.
  - Any pattern with M0&M2 or M1&M3 → shoot-through. Sets o_fault (sticky until reset); sigma is forced to 0 from then on.
  - All other patterns (single device on) → treated as 0000.
- FSM states: IDLE, UPD_I, UPD_V, PUB.
  - IDLE→UPD_I on tick.
  - UPD_I→UPD_V→PUB→IDLE unconditionally.
- UPD_I: I ← sat32(I + ((sigma·(Vg<<<16) − V − D) · K_I) >>> SH). D = R_DAMP·I when damping is compiled in, else 0.
- UPD_V: V ← sat32(V + (I · K_V) >>> SH), using the updated I (symplectic Euler).
- PUB: o_vC, o_iC and o_sigma are loaded from V, I and the decoded sigma; o_valid=1 for this one cycle.
- Arithmetic: 64-bit signed products. sat32 clamps to [−2^31, 2^31−1] and never wraps.
- A tick arriving while the FSM is not in IDLE is impossible because DIV ≥ 4. Elaboration fails if DIV < 4.

## Timing
- Reset (async assert, sync release): V=0, I=0, cnt=0, FSM=IDLE, m_q=0000. Outputs: o_vC=0, o_iC=0, o_sigma=00, o_valid=0, o_fault=0.
- Reset asserted mid-update aborts the step; no partial state survives.
- Latency: tick cycle → o_valid high 3 clocks later. A change on i_MOSFET affects the next step only if it arrives ≥ 1 clock before the tick, because of the m_q stage.
- o_valid period = DIV clocks while enabled.
- Deasserting i_enable during UPD_I/UPD_V/PUB lets the step finish; only the divider freezes.
- A shoot-through pattern sets o_fault in the same PUB as the step that sampled it.

## Configuration
- TANK_DAMPING_EN defined: the R_DAMP·I term is subtracted in UPD_I, giving a lossy tank.
- TANK_DAMPING_EN undefined: D=0, the tank is lossless, and R_DAMP is ignored. This removes one multiplier.

## Structure
- Package resonant_tank_pkg holds:
  - FSM state enum.
  - sigma encodings SIG_POS/SIG_ZERO/SIG_NEG.
  - MOSFET pattern constants PAT_POS=1001, PAT_NEG=0110, PAT_FW_H=0011, PAT_FW_L=1100, PAT_OFF=0000.
  - sat32 function.
- Sub-module mosfet_pattern_decoder: combinational. Inputs are m_q and sign(I). Outputs are sigma and shoot_through.

## Test plan
- Reset, i_enable=1, DIV=8, i_MOSFET=1001, i_Vg=1000 → first o_valid 11 clocks after reset release; o_sigma=01; o_iC strictly increasing over the first 3 steps.
- Alternate 1001/0110 every 40 steps → o_vC/o_iC oscillate in sign; o_sigma follows 01/11 with one-step lag relative to the command change.
- Force I>0, then apply i_MOSFET=0000 → o_sigma=11 at the next PUB. With I<0 → 01. With I=0 → 00.
- i_MOSFET=0101 for one tick → o_fault=1 from that PUB on. It stays 1 after returning to 1001, and o_sigma stays 00 until i_RESET.
- i_Vg=32767, constant 1001 for 10^5 steps → o_iC saturates at 0x1FFF with no wrap to negative.
- Assert i_RESET in the UPD_V cycle → all outputs 0 immediately. First o_valid after release arrives DIV+3 clocks later. With TANK_DAMPING_EN, free oscillation (0011 held) decays in amplitude; without it, amplitude stays within ±1 LSB per cycle.

Source files
------------

// File: rtl/resonant_tank_pkg.sv
// Shared types and constants for the resonant tank plant model.
// Optional lossy tank: define TANK_DAMPING_EN.
package resonant_tank_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_UPD_I = 2'd1,
    S_UPD_V = 2'd2,
    S_PUB   = 2'd3
  } tank_state_e;

  // Bridge state as a 2-bit two's-complement value (+1, 0, -1)
  localparam logic [1:0] SIG_POS  = 2'b01;
  localparam logic [1:0] SIG_ZERO = 2'b00;
  localparam logic [1:0] SIG_NEG  = 2'b11;

  // Gate patterns, bit order M3..M0
  localparam logic [3:0] PAT_POS  = 4'b1001;
  localparam logic [3:0] PAT_NEG  = 4'b0110;
  localparam logic [3:0] PAT_FW_H = 4'b0011;
  localparam logic [3:0] PAT_FW_L = 4'b1100;
  localparam logic [3:0] PAT_OFF  = 4'b0000;

  localparam logic signed [63:0] SAT_MAX = 64'sd2147483647;
  localparam logic signed [63:0] SAT_MIN = -64'sd2147483648;

  function automatic logic signed [31:0] sat32(input logic signed [63:0] x);
    logic signed [31:0] r;
    if (x > SAT_MAX)      r = 32'sh7FFF_FFFF;
    else if (x < SAT_MIN) r = 32'sh8000_0000;
    else                  r = x[31:0];
    return r;
  endfunction

endpackage

// File: rtl/mosfet_pattern_decoder.sv
// Maps the registered gate word to a bridge state; flags shoot-through.
// Open / single-device patterns follow diode conduction: sigma = -sign(I).
module mosfet_pattern_decoder
  import resonant_tank_pkg::*;
(
  input  logic [3:0] m_i,
  input  logic       i_neg_i,
  input  logic       i_zero_i,
  output logic [1:0] sigma_o,
  output logic       shoot_o
);

  always_comb begin
    shoot_o = (m_i[0] & m_i[2]) | (m_i[1] & m_i[3]);
    sigma_o = SIG_ZERO;
    if (!shoot_o) begin
      unique case (m_i)
        PAT_POS:            sigma_o = SIG_POS;
        PAT_NEG:            sigma_o = SIG_NEG;
        PAT_FW_H, PAT_FW_L: sigma_o = SIG_ZERO;
        default:            sigma_o = i_zero_i ? SIG_ZERO : (i_neg_i ? SIG_POS : SIG_NEG);
      endcase
    end
  end

endmodule

// File: rtl/resonant_tank_emulator.sv
// Discrete-time series LC tank driven by a decoded H-bridge (symplectic Euler).
// Define TANK_DAMPING_EN to subtract R_DAMP*I in the current update.
module resonant_tank_emulator
  import resonant_tank_pkg::*;
#(
  parameter int unsigned DIV    = 32'd50,
  parameter int          K_I    = 32'd86,
  parameter int          K_V    = 32'd90,
  parameter int          R_DAMP = 32'd2,
  parameter int unsigned SH     = 32'd10
) (
  input  logic               i_clock,
  input  logic               i_RESET,
  input  logic               i_enable,
  input  logic [3:0]         i_MOSFET,
  input  logic signed [15:0] i_Vg,
  output logic signed [13:0] o_vC,
  output logic signed [13:0] o_iC,
  output logic [1:0]         o_sigma,
  output logic               o_valid,
  output logic               o_fault
);

  generate
    if (DIV < 4 || R_DAMP < 0) begin : g_bad_cfg
      $error("resonant_tank_emulator: DIV must be >= 4 and R_DAMP >= 0");
    end
  endgenerate

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  tank_state_e state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [3:0]         m_q;
  logic [1:0]         sig_q;
  logic               st_q;
  logic signed [31:0] I_q, I_d, V_q, V_d;
  logic signed [13:0] vc_q, ic_q;
  logic [1:0]         sigo_q;
  logic               valid_q, fault_q;

  logic tick, latch_cmd, upd_i, upd_v, pub;
  logic [1:0] dec_sig;
  logic       dec_st;

  assign tick = i_enable && (cnt_q == CNT_LAST);

  mosfet_pattern_decoder u_dec (
    .m_i      (m_q),
    .i_neg_i  (I_q[31]),
    .i_zero_i (I_q == 32'sd0),
    .sigma_o  (dec_sig),
    .shoot_o  (dec_st)
  );

  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (tick) state_d = S_UPD_I;
      S_UPD_I: state_d = S_UPD_V;
      S_UPD_V: state_d = S_PUB;
      S_PUB:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    latch_cmd = (state_q == S_IDLE) && tick;
    upd_i     = (state_q == S_UPD_I);
    upd_v     = (state_q == S_UPD_V);
    pub       = (state_q == S_PUB);
  end

  logic signed [63:0] vg64, i64, v64, drive, dterm, prod_i, prod_v;

  always_comb begin
    vg64  = 64'(signed'({i_Vg, 16'h0000}));
    i64   = 64'(I_q);
    v64   = 64'(V_q);
    drive = 64'sd0;
    unique case (sig_q)
      SIG_POS: drive = vg64;
      SIG_NEG: drive = -vg64;
      default: drive = 64'sd0;
    endcase
`ifdef TANK_DAMPING_EN
    dterm = 64'(R_DAMP) * i64;
`else
    dterm = 64'sd0;
`endif
    prod_i = (drive - v64 - dterm) * 64'(K_I);
    I_d    = sat32(i64 + (prod_i >>> SH));
    // UPD_V runs the cycle after UPD_I, so I_q already holds the new current
    prod_v = i64 * 64'(K_V);
    V_d    = sat32(v64 + (prod_v >>> SH));
  end

  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      cnt_q   <= '0;
      m_q     <= PAT_OFF;
      sig_q   <= SIG_ZERO;
      st_q    <= 1'b0;
      I_q     <= '0;
      V_q     <= '0;
      vc_q    <= '0;
      ic_q    <= '0;
      sigo_q  <= SIG_ZERO;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      m_q <= i_MOSFET;
      if (i_enable) cnt_q <= tick ? '0 : cnt_q + 1'b1;
      if (latch_cmd) begin
        sig_q <= fault_q ? SIG_ZERO : dec_sig;
        st_q  <= dec_st;
      end
      if (upd_i) I_q <= I_d;
      if (upd_v) V_q <= V_d;
      valid_q <= pub;
      if (pub) begin
        vc_q    <= V_q[31:18];
        ic_q    <= I_q[31:18];
        sigo_q  <= sig_q;
        fault_q <= fault_q | st_q;
      end
    end
  end

  assign o_vC    = vc_q;
  assign o_iC    = ic_q;
  assign o_sigma = sigo_q;
  assign o_valid = valid_q;
  assign o_fault = fault_q;

endmodule

// File: tb/tb_resonant_tank_emulator.sv
// Self-checking bench: decode table, reset/latency sequences, random steps vs a tank model.
module tb_resonant_tank_emulator;

  localparam int DIV = 8;
  localparam int KI  = 86;
  localparam int KV  = 90;
  localparam int RD  = 2;
  localparam int SHF = 10;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0;
  logic [3:0]         mos = 4'b0000;
  logic signed [15:0] vg = 16'sd0;
  logic signed [13:0] vc, ic;
  logic [1:0]         sig;
  logic               vld, flt;

  int unsigned edge_n = 0;
  int unsigned last_v = 0;
  int n_chk = 0;
  int n_pass = 0;

  longint mI, mV;
  bit     mflt;
  int     max_ic, min_vc;

  typedef struct {
    logic [3:0] cmd;
    int         vgv;
    logic [1:0] sig;
    bit         flt;
  } vec_t;
  vec_t tbl [11];
  logic [3:0] pats [9];

  resonant_tank_emulator #(
    .DIV(DIV), .K_I(KI), .K_V(KV), .R_DAMP(RD), .SH(SHF)
  ) dut (
    .i_clock  (clk),
    .i_RESET  (rst_n),
    .i_enable (en),
    .i_MOSFET (mos),
    .i_Vg     (vg),
    .o_vC     (vc),
    .o_iC     (ic),
    .o_sigma  (sig),
    .o_valid  (vld),
    .o_fault  (flt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic longint sat(input longint x);
    if (x > 64'sd2147483647) return 64'sd2147483647;
    if (x < -64'sd2147483648) return -64'sd2147483648;
    return x;
  endfunction

  // Bridge value the plant sees for a given command, from the pattern rules
  function automatic int m_sig(input logic [3:0] m);
    bit shoot;
    shoot = (m[0] && m[2]) || (m[1] && m[3]);
    if (mflt || shoot) return 0;
    if (m == 4'b1001) return 1;
    if (m == 4'b0110) return -1;
    if (m == 4'b0011 || m == 4'b1100) return 0;
    if (mI > 0) return -1;
    if (mI < 0) return 1;
    return 0;
  endfunction

  task automatic model_step(input logic [3:0] m, input int v, output int s);
    longint drive, d;
    s     = m_sig(m);
    drive = longint'(s) * (longint'(v) * 65536);
    d     = 0;
`ifdef TANK_DAMPING_EN
    d = longint'(RD) * mI;
`endif
    mI = sat(mI + (((drive - mV - d) * KI) >>> SHF));
    mV = sat(mV + ((mI * KV) >>> SHF));
    if ((m[0] && m[2]) || (m[1] && m[3])) mflt = 1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (vld) begin
        ok = 1;
        break;
      end
    end
  endtask

  // Apply one command, optionally freeze the divider for 'hold' clocks, check the step
  task automatic do_step(input logic [3:0] m, input int v, input int hold, input int exp_per);
    bit ok;
    int s;
    logic [1:0] ec;
    mos = m;
    vg  = 16'(v);
    if (hold > 0) begin
      en = 1'b0;
      repeat (hold) @(negedge clk);
      en = 1'b1;
    end
    wait_valid(ok);
    if (!ok) begin
      chk("valid_timeout", 0, 1);
      return;
    end
    if (exp_per > 0) chk("valid_period", longint'(edge_n - last_v), exp_per);
    last_v = edge_n;
    model_step(m, v, s);
    ec = (s == 1) ? 2'b01 : ((s == -1) ? 2'b11 : 2'b00);
    chk("vC", longint'(vc), mV >>> 18);
    chk("iC", longint'(ic), mI >>> 18);
    chk("sigma", longint'(sig), longint'(ec));
    chk("fault", longint'(flt), longint'(mflt));
    if (int'(ic) > max_ic) max_ic = int'(ic);
    if (int'(vc) < min_vc) min_vc = int'(vc);
    @(negedge clk);
    chk("valid_one_cycle", longint'(vld), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mI = 0; mV = 0; mflt = 0;
    repeat (2) @(negedge clk);
    chk("rst_vC", longint'(vc), 0);
    chk("rst_iC", longint'(ic), 0);
    chk("rst_flags", longint'({sig, vld, flt}), 0);
    rst_n  = 1'b1;
    last_v = edge_n;
  endtask

  initial begin
    tbl[0]  = '{4'b0000, 1000, 2'b00, 1'b0};  // diode, I == 0
    tbl[1]  = '{4'b1001, 1000, 2'b01, 1'b0};
    tbl[2]  = '{4'b1001, 1000, 2'b01, 1'b0};
    tbl[3]  = '{4'b0000, 1000, 2'b11, 1'b0};  // diode, I > 0
    tbl[4]  = '{4'b1100, 1000, 2'b00, 1'b0};
    tbl[5]  = '{4'b0011, 1000, 2'b00, 1'b0};
    tbl[6]  = '{4'b0110, 1000, 2'b11, 1'b0};
    tbl[7]  = '{4'b0000, 1000, 2'b01, 1'b0};  // diode, I < 0
    tbl[8]  = '{4'b0101, 1000, 2'b00, 1'b1};  // shoot-through
    tbl[9]  = '{4'b1001, 1000, 2'b00, 1'b1};
    tbl[10] = '{4'b0000, 1000, 2'b00, 1'b1};
    pats = '{4'b1001, 4'b0110, 4'b0011, 4'b1100, 4'b0000,
             4'b0001, 4'b0100, 4'b1000, 4'b0010};
    max_ic = -8192;
    min_vc = 8191;

    en = 1'b1;
    mos = tbl[0].cmd;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      do_step(tbl[i].cmd, tbl[i].vgv, 0, (i == 0) ? DIV + 3 : DIV);
      chk("tbl_sigma", longint'(sig), longint'(tbl[i].sig));
      chk("tbl_fault", longint'(flt), longint'(tbl[i].flt));
    end

    // Abort a step in UPD_V: the last valid edge E was followed by one more edge
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_vC", longint'(vc), 0);
    chk("midrst_iC", longint'(ic), 0);
    chk("midrst_flags", longint'({sig, vld, flt}), 0);
    mI = 0; mV = 0; mflt = 0;
    @(negedge clk);
    mos = 4'b1001;
    rst_n  = 1'b1;
    last_v = edge_n;
    for (int i = 0; i < 3; i++) do_step(4'b1001, 1000, 0, (i == 0) ? DIV + 3 : DIV);

    // Random commands, link voltage and divider freezes
    for (int i = 0; i < 80; i++) begin
      int h;
      int v;
      h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
      v = int'($urandom_range(0, 4000)) - 2000;
      do_step(pats[$urandom_range(0, 8)], v, h, DIV + h);
    end

    // Drive both state variables into saturation
    do_reset();
    for (int i = 0; i < 50; i++) do_step(4'b0110, 32767, 0, (i == 0) ? DIV + 3 : DIV);
    for (int i = 0; i < 60; i++) do_step(4'b1001, 32767, 0, DIV);
`ifndef TANK_DAMPING_EN
    chk("iC_reaches_max", max_ic, 8191);
    chk("vC_reaches_min", min_vc, -8192);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
